// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode helpers for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_MUL = 4'd2;
   localparam logic [3:0] ALU_DIV = 4'd3;
   localparam logic [3:0] ALU_AND = 4'd4;
   localparam logic [3:0] ALU_OR  = 4'd5;
   localparam logic [3:0] ALU_XOR = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   function automatic logic is_muldiv(logic [3:0] sel);
      return (sel == ALU_MUL) || (sel == ALU_DIV);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result handshake bundle between the register-read stage, the ALU and writeback.
interface seq_alu_if #(
   parameter int WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       Sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Out;
   logic [WIDTH-1:0] Hi;
   logic             zero;
   logic             div_by_zero;

   modport master (
      output in_valid, A, B, Sel, out_ready,
      input  in_ready, out_valid, Out, Hi, zero, div_by_zero
   );

   modport slave (
      input  in_valid, A, B, Sel, out_ready,
      output in_ready, out_valid, Out, Hi, zero, div_by_zero
   );

endinterface

// File: rtl/seq_muldiv.sv
// Iterative datapath: shift-add multiply and restoring shift-subtract divide, one bit per cycle.
module seq_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // hi:lo is the product / remainder:quotient accumulator; op holds multiplicand or divisor
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             active_q, active_d;

   logic [WIDTH:0] step_sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      lo_d     = lo_q;
      hi_d     = hi_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      active_d = active_q;
      step_sum = {1'b0, hi_q} + {1'b0, op_q};
      shifted  = {hi_q, lo_q[WIDTH-1]};
      trial    = shifted - {1'b0, op_q};

      if (start) begin
         lo_d     = is_div ? a : b;
         op_d     = is_div ? b : a;
         hi_d     = '0;
         cnt_d    = CNT_W'(WIDTH);
         div_d    = is_div;
         active_d = 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (div_q) begin
            if (shifted >= {1'b0, op_q}) begin
               hi_d = trial[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = shifted[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else if (lo_q[0]) begin
            {hi_d, lo_d} = {step_sum, lo_q[WIDTH-1:1]};
         end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
         end
      end else if (active_q) begin
         active_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_q     <= '0;
         hi_q     <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         active_q <= active_d;
      end
   end

   // Result is final the cycle after the last step, when the counter has drained.
   assign done = active_q && (cnt_q == '0);
   assign lo   = lo_q;
   assign hi   = hi_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: handshake FSM, single-cycle ops and registered results; MUL/DIV are
// delegated to seq_muldiv.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     reset,
   seq_alu_if.slave bus
);

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       sel_q, sel_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;

   logic             md_start;
   logic             md_done;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] alu_res;
   logic             div_zero;

   seq_muldiv #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .is_div (bus.Sel == ALU_DIV),
      .a      (bus.A),
      .b      (bus.B),
      .done   (md_done),
      .lo     (md_lo),
      .hi     (md_hi)
   );

   assign div_zero = (sel_q == ALU_DIV) && (b_q == '0);

   always_comb begin
      alu_res = a_q + b_q;
      case (sel_q)
         ALU_SUB: alu_res = a_q - b_q;
         ALU_AND: alu_res = a_q & b_q;
         ALU_OR:  alu_res = a_q | b_q;
         ALU_XOR: alu_res = a_q ^ b_q;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         default: alu_res = a_q + b_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      out_d    = out_q;
      hi_d     = hi_q;
      zero_d   = zero_q;
      dbz_d    = dbz_q;
      md_start = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d      = bus.A;
               b_d      = bus.B;
               sel_d    = bus.Sel;
               state_d  = S_BUSY;
               // Divide-by-zero never runs the iterative datapath.
               md_start = is_muldiv(bus.Sel) && !((bus.Sel == ALU_DIV) && (bus.B == '0));
            end
         end
         S_BUSY: begin
            if (!is_muldiv(sel_q) || div_zero || md_done) begin
               if (div_zero) begin
                  out_d = '1;
                  hi_d  = a_q;
                  dbz_d = 1'b1;
               end else if (is_muldiv(sel_q)) begin
                  out_d = md_lo;
                  hi_d  = md_hi;
                  dbz_d = 1'b0;
               end else begin
                  out_d = alu_res;
                  hi_d  = '0;
                  dbz_d = 1'b0;
               end
               zero_d  = (out_d == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= ALU_ADD;
         out_q   <= '0;
         hi_q    <= '0;
         zero_q  <= 1'b1;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         hi_q    <= hi_d;
         zero_q  <= zero_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.out_valid   = (state_q == S_DONE);
   assign bus.Out         = out_q;
   assign bus.Hi          = hi_q;
   assign bus.zero        = zero_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: handshake latency, results, hold and reset abort.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32)) bus ();

   seq_alu #(
      .WIDTH(32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] o;
      logic [31:0] h;
      logic [7:0]  lat;
   } vec_t;

   vec_t vecs [0:7];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Presents one op, lets it be accepted, and counts edges until out_valid (bounded).
   task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int ready_seen);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.Sel      = sel;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat          = 0;
      ready_seen   = 0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) ready_seen++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("rel_valid", bus.out_valid, 1'b0);
      check("rel_ready", bus.in_ready, 1'b1);
   endtask

   initial begin
      int lat;
      int rs;
      int pulses;

      vecs[0] = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0, 8'd1};
      vecs[1] = '{ALU_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 32'h0, 8'd1};
      vecs[2] = '{ALU_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 32'h0, 8'd1};
      vecs[3] = '{4'd12,    32'd10,        32'd20,        32'd30,        32'h0, 8'd1};
      vecs[4] = '{ALU_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1, 8'd33};
      vecs[5] = '{ALU_DIV,  32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 32'd5, 8'd33};
      vecs[6] = '{ALU_DIV,  32'd3,         32'd7,         32'd0,         32'd3, 8'd33};
      vecs[7] = '{ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 32'h0, 8'd1};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.Sel       = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out", bus.Out, 32'h0);
      check("rst_hi", bus.Hi, 32'h0);
      check("rst_zero", bus.zero, 1'b1);
      check("rst_dbz", bus.div_by_zero, 1'b0);

      // ADD wrap with the consumer always ready
      bus.out_ready = 1'b1;
      run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, lat, rs);
      check("add_lat", lat, 1);
      check("add_out", bus.Out, 32'h0);
      check("add_zero", bus.zero, 1'b1);
      check("add_hi", bus.Hi, 32'h0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("add_consumed", bus.out_valid, 1'b0);
      check("add_in_ready", bus.in_ready, 1'b1);

      run_op(ALU_MUL, 32'hFFFF_FFFF, 32'd2, lat, rs);
      check("mul_lat", lat, 33);
      check("mul_busy_ready", rs, 0);
      check("mul_out", bus.Out, 32'hFFFF_FFFE);
      check("mul_hi", bus.Hi, 32'h1);
      check("mul_zero", bus.zero, 1'b0);
      release_result();
      check("mul_retain", bus.Out, 32'hFFFF_FFFE);

      run_op(ALU_DIV, 32'd100, 32'd7, lat, rs);
      check("div_lat", lat, 33);
      check("div_out", bus.Out, 32'd14);
      check("div_hi", bus.Hi, 32'd2);
      check("div_dbz", bus.div_by_zero, 1'b0);
      release_result();

      run_op(ALU_DIV, 32'd5, 32'd0, lat, rs);
      check("dbz_lat", lat, 1);
      check("dbz_out", bus.Out, 32'hFFFF_FFFF);
      check("dbz_hi", bus.Hi, 32'd5);
      check("dbz_flag", bus.div_by_zero, 1'b1);
      release_result();

      // SLT held while the consumer stalls; operands changed to show they were latched
      run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, lat, rs);
      bus.A = 32'd9;
      bus.B = 32'd0;
      for (int i = 0; i < 5; i++) begin
         check("slt_hold_valid", bus.out_valid, 1'b1);
         check("slt_hold_out", bus.Out, 32'd1);
         @(posedge clk);
         #1;
      end
      check("slt_dbz", bus.div_by_zero, 1'b0);
      release_result();
      run_op(ALU_SLT, 32'd1, 32'hFFFF_FFFF, lat, rs);
      check("slt_false", bus.Out, 32'd0);
      check("slt_false_zero", bus.zero, 1'b1);
      release_result();

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].sel, vecs[i].a, vecs[i].b, lat, rs);
         check($sformatf("vec%0d_lat", i), lat, 64'(vecs[i].lat));
         check($sformatf("vec%0d_out", i), bus.Out, 64'(vecs[i].o));
         check($sformatf("vec%0d_hi", i), bus.Hi, 64'(vecs[i].h));
         check($sformatf("vec%0d_zero", i), bus.zero, 64'(vecs[i].o == 32'h0));
         release_result();
      end

      // Reset during BUSY cycle 10 of a DIV
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A        = 32'd100;
      bus.B        = 32'd7;
      bus.Sel      = ALU_DIV;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy", bus.in_ready, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_in_ready", bus.in_ready, 1'b1);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_out", bus.Out, 32'h0);
      check("abort_hi", bus.Hi, 32'h0);
      check("abort_zero", bus.zero, 1'b1);
      check("abort_dbz", bus.div_by_zero, 1'b0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) pulses++;
         @(posedge clk);
         #1;
      end
      check("abort_no_pulse", pulses, 0);

      run_op(ALU_ADD, 32'd7, 32'd8, lat, rs);
      check("post_add_lat", lat, 1);
      check("post_add_out", bus.Out, 32'd15);
      check("post_add_zero", bus.zero, 1'b0);
      release_result();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
